// File: rtl/gps_code_pkg.sv
// Shared types and constants for the GPS spreading-code generator.
// The L-code key table exists only when GPS_LCODE_EN is defined.
package gps_code_pkg;

  localparam int CA_DIV   = 10;   // clocks per C/A chip
  localparam int P_BITS   = 128;  // P-code block length and l_code width
  localparam int MIX_RNDS = 4;    // L-code mixing rounds
  localparam int CA_WIN   = 13;   // C/A output window
  localparam int DLY_LEN  = 64;   // X2 delay line length
  localparam int MIX_ROT  = 13;   // left rotation per mixing round

  localparam int CHIP_W  = $clog2(P_BITS);
  localparam int PRESC_W = $clog2(CA_DIV);
  localparam int RND_W   = $clog2(MIX_RNDS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_MIX,
    ST_DONE
  } state_e;

  // C/A registers are numbered 1..10 as in the ICD; stage 10 is the output.
  localparam logic [10:1] G_INIT  = 10'h3FF;
  localparam logic [10:1] G1_TAPS = 10'h204;  // stages 10,3
  localparam logic [10:1] G2_TAPS = 10'h3A6;  // stages 10,9,8,6,3,2

  // P-code LFSRs: 12-bit, shift left, feedback enters bit 0.
  localparam logic [11:0] X_RST   = 12'hFFF;
  localparam logic [11:0] X1_INIT = 12'h248;
  localparam logic [11:0] X2_INIT = 12'h964;
  localparam logic [11:0] X1_TAPS = 12'hCA0;  // bits 11,10,7,5
  localparam logic [11:0] X2_TAPS = 12'hFDD;  // bits 11,10,9,8,7,6,4,3,2,0

  // G2 phase-select pair for one PRN.
  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
  } g2_sel_t;

  // Standard phase-select pairs for PRN 1..32, stored {s1,s2} (A = stage 10).
  localparam g2_sel_t G2_SEL [32] = '{
    8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
    8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
    8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
    8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
  };

  // PRN 0 and PRNs above 32 fall back to the PRN1 pair.
  function automatic g2_sel_t g2_select(input logic [5:0] sv);
    logic [5:0] idx;
    idx = (sv == 6'd0 || sv > 6'd32) ? 6'd0 : sv - 6'd1;
    return G2_SEL[idx[4:0]];
  endfunction

`ifdef GPS_LCODE_EN
  localparam logic [P_BITS-1:0] LKEY [MIX_RNDS] = '{
    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
    128'hA5A5_5A5A_C3C3_3C3C_9696_6969_F00F_0FF0,
    128'h1357_9BDF_2468_ACE0_0ECA_8642_FDB9_7531,
    128'hDEAD_BEEF_CAFE_F00D_8BAD_F00D_0D15_EA5E
  };

  function automatic logic [P_BITS-1:0] rotl(input logic [P_BITS-1:0] v);
    return {v[P_BITS-1-MIX_ROT:0], v[P_BITS-1:P_BITS-MIX_ROT]};
  endfunction
`endif

endpackage

// File: rtl/gps_code_if.sv
// Bus between the satellite-select logic (master) and the code generator (slave).
interface gps_code_if;
  import gps_code_pkg::*;

  logic [5:0]        sv_num;
  logic              startRound;
  logic [CA_WIN-1:0] ca_code;
  logic [P_BITS-1:0] p_code;
  logic [P_BITS-1:0] l_code;
  logic              l_code_valid;

  modport master (
    output sv_num, startRound,
    input  ca_code, p_code, l_code, l_code_valid
  );

  modport slave (
    input  sv_num, startRound,
    output ca_code, p_code, l_code, l_code_valid
  );
endinterface

// File: rtl/gps_ca_gen.sv
// GPS C/A code generator: G1/G2 LFSRs, PRN phase select, 13-chip window.
// load_i reloads the LFSRs and clears the window; step_i emits one chip.
module gps_ca_gen
  import gps_code_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n_in,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [5:0]        sv_i,
  output logic [CA_WIN-1:0] ca_code_o
);

  logic [10:1]       g1_q, g1_d;
  logic [10:1]       g2_q, g2_d;
  logic [CA_WIN-1:0] ca_q, ca_d;
  g2_sel_t           sel;
  logic              cachip;

  // Current chip from G1 output and the two phase-selected G2 stages.
  always_comb begin
    sel    = g2_select(sv_i);
    cachip = g1_q[10] ^ g2_q[sel.s1] ^ g2_q[sel.s2];
  end

  // Reload on round start, otherwise shift the window and step both LFSRs.
  // NOTE: every signal written here gets its hold value first, so no path leaves a latch behind.
  always_comb begin
    g1_d = g1_q;
    g2_d = g2_q;
    ca_d = ca_q;
    if (load_i) begin
      g1_d = G_INIT;
      g2_d = G_INIT;
      ca_d = '0;
    end else if (step_i) begin
      ca_d = {ca_q[CA_WIN-2:0], cachip};
      g1_d = {g1_q[9:1], ^(g1_q & G1_TAPS)};
      g2_d = {g2_q[9:1], ^(g2_q & G2_TAPS)};
    end
  end

  // C/A state registers.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      g1_q <= G_INIT;
      g2_q <= G_INIT;
      ca_q <= '0;
    end else begin
      g1_q <= g1_d;
      g2_q <= g2_d;
      ca_q <= ca_d;
    end
  end

  assign ca_code_o = ca_q;

endmodule

// File: rtl/gps_code_gen.sv
// GPS spreading-code generator top: round FSM, P-code generator, X2 delay
// line and (with GPS_LCODE_EN defined) the keyed 4-round L-code mixer.
// Without GPS_LCODE_EN, l_code/l_code_valid are tied low and RUN returns
// straight to IDLE.
module gps_code_gen
  import gps_code_pkg::*;
(
  input logic       clk,
  input logic       rst_n_in,
  gps_code_if.slave bus
);

  state_e             state_q, state_d;
  logic [CHIP_W-1:0]  chip_q, chip_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [5:0]         sv_q, sv_d;
  logic [11:0]        x1_q, x1_d;
  logic [11:0]        x2_q, x2_d;
  logic [DLY_LEN-1:0] dly_q, dly_d;
  logic [P_BITS-1:0]  p_q, p_d;

  logic start, run, last_chip, ca_step, pchip;

`ifdef GPS_LCODE_EN
  logic [P_BITS-1:0] mix_q, mix_d;
  logic [P_BITS-1:0] l_q, l_d;
  logic [RND_W-1:0]  rnd_q, rnd_d;
  logic              lv_q, lv_d;
  logic              mix_en, done;
`endif

  assign last_chip = (chip_q == CHIP_W'(P_BITS - 1));

  // The first C/A chip lands on RUN clock 0, then every CA_DIV clocks (13 chips per round).
  assign ca_step = run && (presc_q == '0);

  // PRN 0 takes X2 undelayed; otherwise X2 delayed by sv_q chips.
  assign pchip = x1_q[11] ^ ((sv_q == 6'd0) ? x2_q[11] : dly_q[sv_q - 6'd1]);

  // Next state and per-state strobes; startRound only matters in IDLE.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    run     = 1'b0;
`ifdef GPS_LCODE_EN
    mix_en  = 1'b0;
    done    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.startRound) begin
          start   = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        run = 1'b1;
        if (last_chip) begin
`ifdef GPS_LCODE_EN
          state_d = ST_MIX;
`else
          state_d = ST_IDLE;
`endif
        end
      end
`ifdef GPS_LCODE_EN
      ST_MIX: begin
        mix_en = 1'b1;
        if (rnd_q == RND_W'(MIX_RNDS - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // P-code datapath: reload at round start, one chip per RUN clock.
  always_comb begin
    sv_d    = sv_q;
    chip_d  = chip_q;
    presc_d = presc_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    dly_d   = dly_q;
    p_d     = p_q;
    if (start) begin
      sv_d    = bus.sv_num;
      chip_d  = '0;
      presc_d = '0;
      x1_d    = X1_INIT;
      x2_d    = X2_INIT;
      dly_d   = '0;
      p_d     = '0;
    end else if (run) begin
      chip_d  = chip_q + CHIP_W'(1);
      presc_d = (presc_q == PRESC_W'(CA_DIV - 1)) ? '0 : presc_q + PRESC_W'(1);
      x1_d    = {x1_q[10:0], ^(x1_q & X1_TAPS)};
      x2_d    = {x2_q[10:0], ^(x2_q & X2_TAPS)};
      dly_d   = {dly_q[DLY_LEN-2:0], x2_q[11]};
      p_d     = {p_q[P_BITS-2:0], pchip};
    end
  end

  // P-code registers.
  // NOTE: the delay line is plain flops, not a RAM, so it takes the async reset like every other register.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sv_q    <= '0;
      chip_q  <= '0;
      presc_q <= '0;
      x1_q    <= X_RST;
      x2_q    <= X_RST;
      dly_q   <= '0;
      p_q     <= '0;
    end else begin
      sv_q    <= sv_d;
      chip_q  <= chip_d;
      presc_q <= presc_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      dly_q   <= dly_d;
      p_q     <= p_d;
    end
  end

  gps_ca_gen u_ca (
    .clk       (clk),
    .rst_n_in  (rst_n_in),
    .load_i    (start),
    .step_i    (ca_step),
    .sv_i      (sv_q),
    .ca_code_o (bus.ca_code)
  );

  assign bus.p_code = p_q;

`ifdef GPS_LCODE_EN
  // Mixer: capture the full block (including the 128th chip), rotate-XOR per round, publish on DONE.
  always_comb begin
    mix_d = mix_q;
    rnd_d = rnd_q;
    l_d   = l_q;
    lv_d  = 1'b0;
    if (run && last_chip) begin
      mix_d = p_d;
      rnd_d = '0;
    end else if (mix_en) begin
      mix_d = rotl(mix_q) ^ LKEY[rnd_q];
      rnd_d = rnd_q + RND_W'(1);
    end else if (done) begin
      l_d  = mix_q;
      lv_d = 1'b1;
    end
  end

  // Mixer and output registers.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mix_q <= '0;
      rnd_q <= '0;
      l_q   <= '0;
      lv_q  <= 1'b0;
    end else begin
      mix_q <= mix_d;
      rnd_q <= rnd_d;
      l_q   <= l_d;
      lv_q  <= lv_d;
    end
  end

  assign bus.l_code       = l_q;
  assign bus.l_code_valid = lv_q;
`else
  assign bus.l_code       = '0;
  assign bus.l_code_valid = 1'b0;
`endif

endmodule

// File: tb/tb_gps_code_gen.sv
// Self-checking bench for gps_code_gen. Reference model computes C/A and
// P chips from the polynomial/phase-select rules with integer arrays and the
// L-code with an index-arithmetic rotation. Honours GPS_LCODE_EN.
module tb_gps_code_gen;

  logic clk = 1'b0;
  logic rst_n_in;
  always #5 clk = ~clk;

  gps_code_if bus ();

  gps_code_gen dut (
    .clk      (clk),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

`ifdef GPS_LCODE_EN
  localparam int ROUND_LEN = 133;
  logic [127:0] lkey [4] = '{
    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
    128'hA5A5_5A5A_C3C3_3C3C_9696_6969_F00F_0FF0,
    128'h1357_9BDF_2468_ACE0_0ECA_8642_FDB9_7531,
    128'hDEAD_BEEF_CAFE_F00D_8BAD_F00D_0D15_EA5E
  };
`else
  localparam int ROUND_LEN = 128;
`endif

  int s1_tab[32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int s2_tab[32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = -1;
  logic [127:0] last_pulse_l = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.l_code_valid !== 1'b0) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      last_pulse_l   = bus.l_code;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int bit_of(input int v, input int i);
    return (v >> i) & 1;
  endfunction

  // Window of the last 13 C/A chips after n_chips chips of PRN sv.
  function automatic logic [12:0] ca_model(input int sv, input int n_chips);
    int g1[11];
    int g2[11];
    int a, b, f1, f2;
    logic [12:0] w;
    a = (sv == 0 || sv > 32) ? 2 : s1_tab[sv-1];
    b = (sv == 0 || sv > 32) ? 6 : s2_tab[sv-1];
    for (int i = 1; i <= 10; i++) begin
      g1[i] = 1;
      g2[i] = 1;
    end
    w = '0;
    for (int k = 0; k < n_chips; k++) begin
      w  = {w[11:0], 1'(g1[10] ^ g2[a] ^ g2[b])};
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      for (int i = 10; i > 1; i--) begin
        g1[i] = g1[i-1];
        g2[i] = g2[i-1];
      end
      g1[1] = f1;
      g2[1] = f2;
    end
    return w;
  endfunction

  // 128-chip P block; chip k of the round ends up at bit 127-k.
  function automatic logic [127:0] p_model(input int sv);
    int x1, x2, f1, f2, chip, x1msb;
    int x2msb[128];
    logic [127:0] p;
    x1 = 'h248;
    x2 = 'h964;
    p  = '0;
    for (int k = 0; k < 128; k++) begin
      x1msb    = bit_of(x1, 11);
      x2msb[k] = bit_of(x2, 11);
      if (sv == 0)        chip = x1msb ^ x2msb[k];
      else if (k >= sv)   chip = x1msb ^ x2msb[k-sv];
      else                chip = x1msb;
      p  = {p[126:0], 1'(chip)};
      f1 = bit_of(x1,11) ^ bit_of(x1,10) ^ bit_of(x1,7) ^ bit_of(x1,5);
      f2 = bit_of(x2,11) ^ bit_of(x2,10) ^ bit_of(x2,9) ^ bit_of(x2,8) ^ bit_of(x2,7)
         ^ bit_of(x2,6) ^ bit_of(x2,4) ^ bit_of(x2,3) ^ bit_of(x2,2) ^ bit_of(x2,0);
      x1 = ((x1 << 1) & 'hFFF) | f1;
      x2 = ((x2 << 1) & 'hFFF) | f2;
    end
    return p;
  endfunction

`ifdef GPS_LCODE_EN
  function automatic logic [127:0] l_model(input logic [127:0] p);
    logic [127:0] st, nx;
    st = p;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 128; i++) nx[(i + 13) % 128] = st[i];
      st = nx ^ lkey[r];
    end
    return st;
  endfunction
`endif

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request a round at the next edge, then scramble sv_num to prove it was latched.
  task automatic start_round(input int sv);
    bus.sv_num     = 6'(sv);
    bus.startRound = 1'b1;
    tick();
    bus.startRound = 1'b0;
    bus.sv_num     = 6'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n_in       = 1'b0;
    bus.startRound = 1'b1;
    bus.sv_num     = 6'd1;
    repeat (5) tick();
    checks++; if (bus.ca_code !== 13'd0) begin failures++; $display("FAIL reset_ca got=%h exp=0", bus.ca_code); end
    checks++; if (bus.p_code !== 128'd0) begin failures++; $display("FAIL reset_p got=%h exp=0", bus.p_code); end
    checks++; if (bus.l_code !== 128'd0) begin failures++; $display("FAIL reset_l got=%h exp=0", bus.l_code); end
    checks++; if (bus.l_code_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.l_code_valid); end
    bus.startRound = 1'b0;
    rst_n_in       = 1'b1;
    repeat (20) tick();
    checks++; if (bus.p_code !== 128'd0) begin failures++; $display("FAIL idle_after_reset_p got=%h exp=0", bus.p_code); end
    checks++; if (bus.ca_code !== 13'd0) begin failures++; $display("FAIL idle_after_reset_ca got=%h exp=0", bus.ca_code); end
    checks++; if (pulse_cnt !== 0) begin failures++; $display("FAIL idle_after_reset_pulses got=%0d exp=0", pulse_cnt); end
  endtask

  // First 10 C/A chips of a PRN land in ca_code[9:0] after the 10th chip (edge 91).
  task automatic test_ca_prefix(input int sv, input logic [9:0] exp10);
    start_round(sv);
    repeat (91) tick();
    checks++;
    if (bus.ca_code[9:0] !== exp10) begin
      failures++;
      $display("FAIL ca_prefix sv=%0d got=%b exp=%b", sv, bus.ca_code[9:0], exp10);
    end
    repeat (ROUND_LEN - 91) tick();
  endtask

  // One full round; with disturb set, startRound/sv_num toggle randomly mid-round.
  task automatic test_full_round(input int sv, input bit disturb);
    int p0, c0;
    logic [127:0] exp_p;
    logic [12:0]  exp_ca;
    exp_p  = p_model(sv);
    exp_ca = ca_model(sv, 13);
    p0 = pulse_cnt;
    start_round(sv);
    c0 = cyc;
    for (int k = 1; k <= 128; k++) begin
      if (disturb && k <= 120) begin
        bus.startRound = 1'($urandom_range(0, 1));
        bus.sv_num     = 6'($urandom);
      end else begin
        bus.startRound = 1'b0;
      end
      tick();
    end
    checks++; if (bus.p_code !== exp_p) begin failures++; $display("FAIL round_p sv=%0d got=%h exp=%h", sv, bus.p_code, exp_p); end
    checks++; if (bus.ca_code !== exp_ca) begin failures++; $display("FAIL round_ca sv=%0d got=%h exp=%h", sv, bus.ca_code, exp_ca); end
    repeat (6) tick();
    checks++; if (bus.p_code !== exp_p) begin failures++; $display("FAIL hold_p sv=%0d got=%h exp=%h", sv, bus.p_code, exp_p); end
    checks++; if (bus.ca_code !== exp_ca) begin failures++; $display("FAIL hold_ca sv=%0d got=%h exp=%h", sv, bus.ca_code, exp_ca); end
`ifdef GPS_LCODE_EN
    checks++; if (pulse_cnt !== p0 + 1) begin failures++; $display("FAIL pulse_count sv=%0d got=%0d exp=%0d", sv, pulse_cnt - p0, 1); end
    checks++; if (last_pulse_cyc !== c0 + 133) begin failures++; $display("FAIL pulse_latency sv=%0d got=%0d exp=133", sv, last_pulse_cyc - c0); end
    checks++; if (last_pulse_l !== l_model(exp_p)) begin failures++; $display("FAIL l_code sv=%0d got=%h exp=%h", sv, last_pulse_l, l_model(exp_p)); end
    checks++; if (bus.l_code !== l_model(exp_p)) begin failures++; $display("FAIL l_hold sv=%0d got=%h exp=%h", sv, bus.l_code, l_model(exp_p)); end
`else
    checks++; if (pulse_cnt !== p0) begin failures++; $display("FAIL no_pulse sv=%0d got=%0d exp=0", sv, pulse_cnt - p0); end
    checks++; if (bus.l_code !== 128'd0) begin failures++; $display("FAIL l_tied sv=%0d got=%h exp=0", sv, bus.l_code); end
`endif
  endtask

  // Second round requested in the IDLE cycle right after the first completes.
  task automatic test_back_to_back(input int sv_a, input int sv_b);
    int p0, c1;
    p0 = pulse_cnt;
    start_round(sv_a);
    repeat (ROUND_LEN) tick();
    checks++; if (bus.p_code !== p_model(sv_a)) begin failures++; $display("FAIL b2b_first_p got=%h exp=%h", bus.p_code, p_model(sv_a)); end
    start_round(sv_b);
    c1 = cyc;
    repeat (128) tick();
    checks++; if (bus.p_code !== p_model(sv_b)) begin failures++; $display("FAIL b2b_second_p got=%h exp=%h", bus.p_code, p_model(sv_b)); end
    checks++; if (bus.ca_code !== ca_model(sv_b, 13)) begin failures++; $display("FAIL b2b_second_ca got=%h exp=%h", bus.ca_code, ca_model(sv_b, 13)); end
    repeat (6) tick();
`ifdef GPS_LCODE_EN
    checks++; if (pulse_cnt !== p0 + 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulse_cnt - p0); end
    checks++; if (last_pulse_cyc !== c1 + 133) begin failures++; $display("FAIL b2b_latency got=%0d exp=133", last_pulse_cyc - c1); end
    checks++; if (last_pulse_l !== l_model(p_model(sv_b))) begin failures++; $display("FAIL b2b_l got=%h exp=%h", last_pulse_l, l_model(p_model(sv_b))); end
`else
    checks++; if (pulse_cnt !== p0) begin failures++; $display("FAIL b2b_pulses got=%0d exp=0", pulse_cnt - p0); end
`endif
  endtask

  // Reset at RUN clock 60: outputs clear at once and no pulse follows.
  task automatic test_reset_mid(input int sv);
    int p0;
    p0 = pulse_cnt;
    start_round(sv);
    repeat (61) tick();
    rst_n_in = 1'b0;
    #1;
    checks++; if (bus.p_code !== 128'd0) begin failures++; $display("FAIL midreset_p got=%h exp=0", bus.p_code); end
    checks++; if (bus.ca_code !== 13'd0) begin failures++; $display("FAIL midreset_ca got=%h exp=0", bus.ca_code); end
    checks++; if (bus.l_code !== 128'd0) begin failures++; $display("FAIL midreset_l got=%h exp=0", bus.l_code); end
    repeat (2) tick();
    rst_n_in = 1'b1;
    repeat (150) tick();
    checks++; if (pulse_cnt !== p0) begin failures++; $display("FAIL midreset_pulse got=%0d exp=0", pulse_cnt - p0); end
    checks++; if (bus.p_code !== 128'd0) begin failures++; $display("FAIL midreset_idle_p got=%h exp=0", bus.p_code); end
  endtask

  initial begin
    bus.startRound = 1'b0;
    bus.sv_num     = 6'd0;
    rst_n_in       = 1'b0;

    test_reset();
    test_ca_prefix(1,  10'b1100100000);
    test_ca_prefix(2,  10'b1110010000);
    test_ca_prefix(0,  10'b1100100000);
    test_ca_prefix(40, 10'b1100100000);
    test_full_round(0, 1'b0);
    test_full_round($urandom_range(1, 32), 1'b0);
    test_full_round($urandom_range(33, 63), 1'b0);
    test_full_round($urandom_range(1, 63), 1'b1);
    test_back_to_back($urandom_range(0, 63), $urandom_range(1, 63));
    test_reset_mid($urandom_range(1, 63));
    test_full_round($urandom_range(1, 63), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
